pwm_serial_bank: RTL and testbench

Parametrised multi-channel PWM engine that drives an external serial-in/parallel-out latch register, such as the pwm_shift_register chain. It holds one programmable duty value per channel and a shared period counter. Once per PWM step it serialises all channel compare results onto a single data line and then pulses a latch strobe. Successor to the fixed 8-channel, hard-coded-duty generator: it adds runtime duty/period programming, an enable, glitch-free duty updates and a defined frame FSM with no delay-based strobes.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_serial_bank_if.sv | 39 +++
 rtl/pwm_ser_shifter.sv | 104 ++++++++++
 rtl/pwm_serial_bank.sv | 116 +++++++++++
 tb/tb_pwm_serial_bank.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and defaults for the pwm_serial_bank slice.
//   pwm_state_e  : frame FSM states (IDLE / SHIFT / LATCH)
//   DEF_CHANNELS : default channel count
//   DEF_CNT_W    : default counter / period / duty width
//   idx_w()      : width of an index able to address n entries (min 1)
package pwm_pkg;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } pwm_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_serial_bank_if.sv
// pwm_serial_bank_if: control/write bus and serial output bundle of the
// PWM bank.
//   enable, period          : run request and counter terminal value
//   wr_en, wr_addr, wr_data : duty write port
//   s_out, s_valid          : serial compare bit and its shift qualifier
//   latch, frame_done       : end-of-frame strobes
//   busy                    : frame FSM not idle
// modport master: host side (drives control and writes)
// modport slave : PWM bank side
interface pwm_serial_bank_if
    import pwm_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W
);
    localparam int AW = idx_w(CHANNELS);

    logic             enable;
    logic [CNT_W-1:0] period;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [CNT_W-1:0] wr_data;
    logic             s_out;
    logic             s_valid;
    logic             latch;
    logic             frame_done;
    logic             busy;

    modport master (
        output enable, period, wr_en, wr_addr, wr_data,
        input  s_out, s_valid, latch, frame_done, busy
    );

    modport slave (
        input  enable, period, wr_en, wr_addr, wr_data,
        output s_out, s_valid, latch, frame_done, busy
    );

endinterface

// File: rtl/pwm_ser_shifter.sv
// pwm_ser_shifter: frame FSM of the PWM bank. Serialises the compare vector
// MSB-channel first, then issues a one-cycle latch/frame_done strobe.
// Ports:
//   clk, reset       : clock, async active-high reset
//   enable           : run request, sampled in IDLE and LATCH only
//   cmp              : per-channel compare results from the top level
//   s_out, s_valid   : registered serial bit and qualifier
//   latch, frame_done: registered end-of-frame strobes
//   busy             : registered "FSM not in IDLE"
//   start            : IDLE->SHIFT transition happens on this edge
//   frame_end        : last shift bit leaves on this edge (PWM step edge)
//   stop             : LATCH->IDLE transition happens on this edge
module pwm_ser_shifter
    import pwm_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] cmp,
    output logic                s_out,
    output logic                s_valid,
    output logic                latch,
    output logic                frame_done,
    output logic                busy,
    output logic                start,
    output logic                frame_end,
    output logic                stop
);
    localparam int             IW   = idx_w(CHANNELS);
    localparam logic [IW-1:0]  LAST = IW'(CHANNELS - 1);

    pwm_state_e    state;
    logic [IW-1:0] idx;    // channel currently presented on s_out

    // state always mirrors the registered outputs: SHIFT <=> s_valid,
    // LATCH <=> latch, so these decodes mark the edge that leaves a state.
    assign start     = (state == ST_IDLE)  &&  enable;
    assign frame_end = (state == ST_SHIFT) && (idx == '0);
    assign stop      = (state == ST_LATCH) && !enable;

    // NOTE: sequential state uses non-blocking <= so every register in this
    // block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            s_out      <= 1'b0;
            s_valid    <= 1'b0;
            latch      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            latch      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state   <= ST_SHIFT;
                        idx     <= LAST;
                        s_out   <= cmp[LAST];
                        s_valid <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        s_out   <= 1'b0;
                        s_valid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (idx == '0) begin
                        state      <= ST_LATCH;
                        s_out      <= 1'b0;
                        s_valid    <= 1'b0;
                        latch      <= 1'b1;
                        frame_done <= 1'b1;
                    end else begin
                        idx   <= idx - 1'b1;
                        s_out <= cmp[idx - 1'b1];
                    end
                end
                ST_LATCH: begin
                    if (enable) begin
                        state   <= ST_SHIFT;
                        idx     <= LAST;
                        s_out   <= cmp[LAST];
                        s_valid <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    s_out   <= 1'b0;
                    s_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_serial_bank.sv
// pwm_serial_bank: multi-channel PWM engine feeding an external SIPO latch
// register. One shared period counter steps once per frame; each frame
// shifts all channel compares (cnt < duty) out serially, then latches.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : asynchronous active-high reset
//   bus   : pwm_serial_bank_if.slave (enable, period, duty writes, serial out)
// Build option:
//   PWM_SHADOW_EN : duty writes land in shadow registers and are copied to
//                   the active set only when the counter wraps, so a write
//                   never truncates or doubles a pulse. Undefined: writes
//                   hit the active registers directly.
module pwm_serial_bank
    import pwm_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input logic               clk,
    input logic               reset,
    pwm_serial_bank_if.slave  bus
);
    localparam int AW = idx_w(CHANNELS);

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    period_q;
    logic [CNT_W-1:0]    duty [CHANNELS];
    logic [CHANNELS-1:0] cmp;
    logic                start;
    logic                frame_end;
    logic                stop;
    logic                wrap;

    // The counter steps on the edge that ends the last shift bit, so it
    // already holds the next value when the following frame starts.
    assign wrap = frame_end && (cnt == period_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            period_q <= '0;
        end else if (start) begin
            cnt      <= '0;
            period_q <= bus.period;
        end else if (wrap) begin
            cnt      <= '0;
            period_q <= bus.period;
        end else if (frame_end) begin
            cnt <= cnt + 1'b1;
        end else if (stop) begin
            cnt <= '0;
        end
    end

    // Addresses >= CHANNELS match no entry below and are dropped.
    // NOTE: the duty array is a small flop bank, not a RAM macro, so it takes
    // the async reset like any other register.
`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] shadow [CHANNELS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                shadow[k] <= '0;
                duty[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (bus.wr_en && (bus.wr_addr == AW'(k)))
                    shadow[k] <= bus.wr_data;
                if (wrap)
                    duty[k] <= shadow[k];
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++)
                duty[k] <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (bus.wr_en && (bus.wr_addr == AW'(k)))
                    duty[k] <= bus.wr_data;
            end
        end
    end
`endif

    // cnt never exceeds period_q, so duty=0 gives constant 0 and
    // duty>period_q gives constant 1 without extra terms.
    // NOTE: default assignment first keeps this block free of inferred latches.
    always_comb begin
        cmp = '0;
        for (int k = 0; k < CHANNELS; k++)
            cmp[k] = (cnt < duty[k]);
    end

    pwm_ser_shifter #(
        .CHANNELS (CHANNELS)
    ) u_shift (
        .clk        (clk),
        .reset      (reset),
        .enable     (bus.enable),
        .cmp        (cmp),
        .s_out      (bus.s_out),
        .s_valid    (bus.s_valid),
        .latch      (bus.latch),
        .frame_done (bus.frame_done),
        .busy       (bus.busy),
        .start      (start),
        .frame_end  (frame_end),
        .stop       (stop)
    );

endmodule

// File: tb/tb_pwm_serial_bank.sv
// tb_pwm_serial_bank: directed self-checking bench for pwm_serial_bank.
// Main instance: 8 channels; second instance: 6 channels for the
// out-of-range write address case. Expected frame words come from a small
// behavioural model of counter, duty and (optionally) shadow registers.
module tb_pwm_serial_bank;
    import pwm_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    pwm_serial_bank_if #(.CHANNELS(8), .CNT_W(8)) a_if ();
    pwm_serial_bank_if #(.CHANNELS(6), .CNT_W(8)) b_if ();

    pwm_serial_bank #(.CHANNELS(8), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    pwm_serial_bank #(.CHANNELS(6), .CNT_W(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    // behavioural model of the main instance
    logic [7:0] dm [8];   // active duty
    logic [7:0] sm [8];   // shadow duty
    int         mcnt;
    int         mper;
    logic [7:0] d1 [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs_a();
        return {27'd0, a_if.s_out, a_if.s_valid, a_if.latch, a_if.frame_done, a_if.busy};
    endfunction

    function automatic logic [7:0] expw();
        logic [7:0] w;
        for (int k = 0; k < 8; k++)
            w[k] = (mcnt < int'(dm[k]));
        return w;
    endfunction

    task automatic model_wr(input logic [2:0] a, input logic [7:0] d);
`ifdef PWM_SHADOW_EN
        sm[a] = d;
`else
        dm[a] = d;
`endif
    endtask

    task automatic model_start();
        mcnt = 0;
        mper = int'(a_if.period);
    endtask

    task automatic model_adv();
        if (mcnt == mper) begin
            mcnt = 0;
            mper = int'(a_if.period);
`ifdef PWM_SHADOW_EN
            for (int k = 0; k < 8; k++) dm[k] = sm[k];
`endif
        end else begin
            mcnt++;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        a_if.wr_en   = 1'b1;
        a_if.wr_addr = a;
        a_if.wr_data = d;
        tick();
        a_if.wr_en = 1'b0;
        model_wr(a, d);
    endtask

    // Collects one frame: bits in shift order (first bit ends at the MSB of
    // the collected width), cycle of the first s_valid, cycle of the latch.
    task automatic capture(input bit use_b, input int drop_at, input bit do_wr,
                           input logic [2:0] wa, input logic [7:0] wd,
                           output logic [7:0] word, output int nb,
                           output int first_v, output int lat_at, output bit fd_ok);
        logic sv, so, lt, fdn;
        word = '0; nb = 0; first_v = -1; lat_at = -1; fd_ok = 1'b1;
        if (do_wr) begin
            a_if.wr_en   = 1'b1;
            a_if.wr_addr = wa;
            a_if.wr_data = wd;
        end
        for (int c = 0; c < 30; c++) begin
            tick();
            if (c == 0) a_if.wr_en = 1'b0;
            if (c == drop_at) a_if.enable = 1'b0;
            sv  = use_b ? b_if.s_valid    : a_if.s_valid;
            so  = use_b ? b_if.s_out      : a_if.s_out;
            lt  = use_b ? b_if.latch      : a_if.latch;
            fdn = use_b ? b_if.frame_done : a_if.frame_done;
            if (fdn !== lt) fd_ok = 1'b0;
            if (sv) begin
                if (first_v < 0) first_v = c;
                word = {word[6:0], so};
                nb++;
                if (lt) fd_ok = 1'b0;
            end
            if (lt) begin
                lat_at = c;
                break;
            end
        end
    endtask

    // One main-instance frame checked against the model.
    task automatic do_frame(input string tag, input int drop_at, input bit do_wr,
                            input logic [2:0] wa, input logic [7:0] wd);
        logic [7:0] exp;
        logic [7:0] word;
        int         nb, fv, la;
        bit         fd;
        if (do_wr) model_wr(wa, wd);   // only channel 0 is written mid-frame; it compares last
        exp = expw();
        capture(1'b0, drop_at, do_wr, wa, wd, word, nb, fv, la, fd);
        check({tag, "_word"}, 32'(word), 32'(exp));
        // start offset, bit count, latch cycle, frame_done==latch
        check({tag, "_framing"}, {fv[7:0], nb[7:0], la[7:0], 7'd0, fd}, 32'h0008_0801);
        model_adv();
    endtask

    initial begin
        int nv;
        logic [7:0] bword;
        int bnb, bfv, bla;
        bit bfd;

        a_if.enable = 1'b0; a_if.period = '0; a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0;
        b_if.enable = 1'b0; b_if.period = '0; b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0;
        for (int k = 0; k < 8; k++) begin
            dm[k] = '0;
            sm[k] = '0;
        end
        mcnt = 0; mper = 0;
        d1 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs_a(), 32'd0);
        check("reset_state", 32'(dut.u_shift.state), 32'(ST_IDLE));
        reset = 1'b0;
        tick();
        check("idle_outputs", outs_a(), 32'd0);
        check("idle_cnt", 32'(dut.cnt), 32'd0);

        // main PWM run: period 4, five-step period plus one wrapped frame
        for (int k = 0; k < 8; k++) wr(3'(k), d1[k]);
        a_if.period = 8'd4;
        a_if.enable = 1'b1;
        model_start();
        for (int f = 0; f < 6; f++)
            do_frame($sformatf("pwm_f%0d", f), -1, 1'b0, 3'd0, 8'd0);

        // enable dropped during the third shift cycle: frame still completes
        do_frame("drop", 2, 1'b0, 3'd0, 8'd0);
        mcnt = 0;
        tick();
        check("drop_busy", 32'(a_if.busy), 32'd0);
        check("drop_cnt", 32'(dut.cnt), 32'd0);
        nv = 0;
        repeat (4) begin
            tick();
            nv += int'(a_if.s_valid | a_if.latch);
        end
        check("drop_quiet", 32'(nv), 32'd0);

        // bit ordering: only channel 7 set, it is the first bit out
        for (int k = 0; k < 7; k++) wr(3'(k), 8'd0);
        wr(3'd7, 8'd255);
        a_if.enable = 1'b1;
        model_start();
        do_frame("order0", -1, 1'b0, 3'd0, 8'd0);
        do_frame("order1", -1, 1'b0, 3'd0, 8'd0);
        a_if.enable = 1'b0;
        tick();
        check("order_idle", 32'(a_if.busy), 32'd0);

        // duty write of channel 0 while cnt=1
        wr(3'd7, 8'd0);
        a_if.enable = 1'b1;
        model_start();
        do_frame("sh_c0", -1, 1'b0, 3'd0, 8'd0);
        do_frame("sh_c1", -1, 1'b1, 3'd0, 8'd2);
        for (int f = 2; f < 7; f++)
            do_frame($sformatf("sh_f%0d", f), -1, 1'b0, 3'd0, 8'd0);
        a_if.enable = 1'b0;
        tick();

        // reset in the middle of SHIFT
        a_if.enable = 1'b1;
        tick(); tick(); tick();
        check("pre_reset_shift", 32'(a_if.s_valid), 32'd1);
        #2 reset = 1'b1;
        #1 check("reset_async", outs_a(), 32'd0);
        nv = 0;
        repeat (3) begin
            tick();
            nv += int'(a_if.latch | a_if.s_valid | a_if.busy | a_if.frame_done);
        end
        check("reset_no_latch", 32'(nv), 32'd0);
        reset = 1'b0;
        a_if.enable = 1'b0;
        tick();
        check("reset_idle_state", 32'(dut.u_shift.state), 32'(ST_IDLE));
        check("reset_idle_busy", 32'(a_if.busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            dm[k] = '0;
            sm[k] = '0;
        end
        mcnt = 0;

        // period 0: counter parked at 0, channel = (duty != 0)
        a_if.period = 8'd0;
        wr(3'd1, 8'd1);
        a_if.enable = 1'b1;
        model_start();
        for (int f = 0; f < 3; f++)
            do_frame($sformatf("p0_f%0d", f), -1, 1'b0, 3'd0, 8'd0);
        a_if.enable = 1'b0;
        tick();

        // 6-channel instance: addresses 6 and 7 are out of range
        b_if.period = 8'd0;
        b_if.wr_en = 1'b1;
        b_if.wr_addr = 3'd6; b_if.wr_data = 8'hFF; tick();
        b_if.wr_addr = 3'd7; b_if.wr_data = 8'hFF; tick();
        b_if.wr_addr = 3'd5; b_if.wr_data = 8'h01; tick();
        b_if.wr_en = 1'b0;
        b_if.enable = 1'b1;
        capture(1'b1, -1, 1'b0, 3'd0, 8'd0, bword, bnb, bfv, bla, bfd);
`ifdef PWM_SHADOW_EN
        check("b_f0_word", 32'(bword), 32'h00);
`else
        check("b_f0_word", 32'(bword), 32'h20);
`endif
        check("b_f0_framing", {bfv[7:0], bnb[7:0], bla[7:0], 7'd0, bfd}, 32'h0006_0601);
        capture(1'b1, -1, 1'b0, 3'd0, 8'd0, bword, bnb, bfv, bla, bfd);
        check("b_f1_word", 32'(bword), 32'h20);
        b_if.enable = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
